mode_counter: RTL and testbench

- Parametrised, programmable timer/counter; next generation of the free-running 8-bit tick counter.
- Adds:
  - configurable width
  - clock prescaler
  - up/down direction
  - synchronous clear and parallel load
  - free-run, modulo and one-shot modes
  - terminal-count pulse
- Used as the general-purpose timebase and event counter in FPGA top-levels.

---
 rtl/mode_counter.sv | 149 ++++++++++++++
 tb/tb_mode_counter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mode_counter
//  Description : Parametrised programmable timer/counter. A prescaler gates
//                steps of a WIDTH-bit counter that runs up or down in
//                free-run, modulo or one-shot mode. It has a synchronous
//                clear and parallel load, a registered terminal-count pulse
//                and a one-shot done flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mode_counter #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PRE_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             tick
);

    localparam logic [1:0]       c_MODE_MODULO  = 2'b01;
    localparam logic [1:0]       c_MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH-1:0] c_ALL_ONES     = '1;
    localparam logic [WIDTH-1:0] c_ZERO         = '0;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [PRE_W-1:0] r_pre_cnt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic             r_tc;
    logic             w_tc_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_tick;
    logic [WIDTH-1:0] w_count_inc;
    logic [WIDTH-1:0] w_count_dec;
    logic             w_at_term;

    // Prescaler strobe: one step is allowed when the prescaler hits its compare value
    always_comb begin
        w_tick      = en && (r_pre_cnt == prescale) && (r_state == ST_RUN);
        w_count_inc = r_count + WIDTH'(1);
        w_count_dec = r_count - WIDTH'(1);
        w_at_term   = dir ? (r_count == c_ZERO) : (r_count >= limit);
    end

    // Next-state logic: clr beats load, load beats a step, otherwise hold
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pre_nxt   = r_pre_cnt;
        w_done_nxt  = r_done;
        w_tc_nxt    = 1'b0;

        if (clr) begin
            w_count_nxt = c_ZERO;
            w_pre_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_state_nxt = ST_RUN;
        end else if (load) begin
            w_count_nxt = load_val;
            w_pre_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_state_nxt = ST_RUN;
        end else if (en && (r_state == ST_RUN)) begin
            if (w_tick) begin
                w_pre_nxt = '0;
                case (mode)
                    c_MODE_MODULO: begin
                        if (!dir) begin
                            if (r_count >= limit) begin
                                w_count_nxt = c_ZERO;
                                w_tc_nxt    = 1'b1;
                            end else begin
                                w_count_nxt = w_count_inc;
                            end
                        end else begin
                            if (r_count == c_ZERO) begin
                                w_count_nxt = limit;
                                w_tc_nxt    = 1'b1;
                            end else begin
                                w_count_nxt = w_count_dec;
                            end
                        end
                    end
                    c_MODE_ONESHOT: begin
                        // At the terminal value the count freezes and the FSM parks in HALT
                        if (w_at_term) begin
                            w_tc_nxt    = 1'b1;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_HALT;
                        end else begin
                            w_count_nxt = dir ? w_count_dec : w_count_inc;
                        end
                    end
                    default: begin
                        // Free-run (and the reserved encoding): natural wrap
                        w_count_nxt = dir ? w_count_dec : w_count_inc;
                        w_tc_nxt    = dir ? (r_count == c_ZERO) : (r_count == c_ALL_ONES);
                    end
                endcase
            end else begin
                // Wraps naturally at 2^PRE_W if prescale was lowered below pre_cnt
                w_pre_nxt = r_pre_cnt + PRE_W'(1);
            end
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_count   <= c_ZERO;
            r_pre_cnt <= '0;
            r_tc      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pre_cnt <= w_pre_nxt;
            r_tc      <= w_tc_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign done  = r_done;
    assign tick  = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_mode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mode_counter
//  Description : Self-checking bench for mode_counter; an 8-bit instance and
//                a 4-bit/1-bit-prescaler instance run against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mode_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // 8-bit instance
    logic       a_en, a_clr, a_load, a_dir;
    logic [1:0] a_mode;
    logic [7:0] a_load_val, a_limit, a_prescale, count_a;
    logic       tc_a, done_a, tick_a;
    // 4-bit instance
    logic       b_en, b_clr, b_load, b_dir;
    logic [1:0] b_mode;
    logic [3:0] b_load_val, b_limit, count_b;
    logic [0:0] b_prescale;
    logic       tc_b, done_b, tick_b;

    mode_counter #(.WIDTH(8), .PRE_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .clr(a_clr), .load(a_load),
        .load_val(a_load_val), .dir(a_dir), .mode(a_mode), .limit(a_limit),
        .prescale(a_prescale), .count(count_a), .tc(tc_a), .done(done_a), .tick(tick_a)
    );

    mode_counter #(.WIDTH(4), .PRE_W(1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .clr(b_clr), .load(b_load),
        .load_val(b_load_val), .dir(b_dir), .mode(b_mode), .limit(b_limit),
        .prescale(b_prescale), .count(count_b), .tc(tc_b), .done(done_b), .tick(tick_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, index 0 = 8-bit instance, 1 = 4-bit instance
    int m_count[2];
    int m_pre[2];
    int m_done[2];
    int m_halt[2];
    int m_tc[2];
    int exp_tick_a, exp_tick_b;
    logic obs_tick_a, obs_tick_b;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0; m_pre[k] = 0; m_done[k] = 0; m_halt[k] = 0; m_tc[k] = 0;
        end
    endtask

    // One clock edge of the counter, written from the behavioural rules
    task automatic model_edge(input int k, input int w, input int pw, input int c,
                              input int l, input int lv, input int e, input int d,
                              input int md, input int lim, input int ps);
        int maxv;
        int pmax;
        int at_term;
        maxv = (1 << w) - 1;
        pmax = (1 << pw) - 1;
        m_tc[k] = 0;
        if (c != 0) begin
            m_count[k] = 0; m_pre[k] = 0; m_done[k] = 0; m_halt[k] = 0;
        end else if (l != 0) begin
            m_count[k] = lv; m_pre[k] = 0; m_done[k] = 0; m_halt[k] = 0;
        end else if (e != 0 && m_halt[k] == 0) begin
            if (m_pre[k] == ps) begin
                m_pre[k] = 0;
                if (md == 1) begin
                    if (d == 0) begin
                        if (m_count[k] >= lim) begin m_count[k] = 0; m_tc[k] = 1; end
                        else m_count[k] = m_count[k] + 1;
                    end else begin
                        if (m_count[k] == 0) begin m_count[k] = lim; m_tc[k] = 1; end
                        else m_count[k] = m_count[k] - 1;
                    end
                end else if (md == 2) begin
                    at_term = (d != 0) ? int'(m_count[k] == 0) : int'(m_count[k] >= lim);
                    if (at_term != 0) begin
                        m_tc[k] = 1; m_done[k] = 1; m_halt[k] = 1;
                    end else begin
                        m_count[k] = (d != 0) ? m_count[k] - 1 : m_count[k] + 1;
                    end
                end else begin
                    if (d == 0) begin
                        if (m_count[k] == maxv) begin m_count[k] = 0; m_tc[k] = 1; end
                        else m_count[k] = m_count[k] + 1;
                    end else begin
                        if (m_count[k] == 0) begin m_count[k] = maxv; m_tc[k] = 1; end
                        else m_count[k] = m_count[k] - 1;
                    end
                end
            end else begin
                m_pre[k] = (m_pre[k] + 1) & pmax;
            end
        end
    endtask

    // Advance one clock: sample tick mid-cycle, then update the model at the edge
    task automatic step();
        @(negedge clk);
        exp_tick_a = (a_en && m_pre[0] == int'(a_prescale) && m_halt[0] == 0) ? 1 : 0;
        exp_tick_b = (b_en && m_pre[1] == int'(b_prescale) && m_halt[1] == 0) ? 1 : 0;
        obs_tick_a = tick_a;
        obs_tick_b = tick_b;
        @(posedge clk);
        model_edge(0, 8, 8, a_clr, a_load, a_load_val, a_en, a_dir, a_mode, a_limit, a_prescale);
        model_edge(1, 4, 1, b_clr, b_load, b_load_val, b_en, b_dir, b_mode, b_limit, b_prescale);
        #1;
    endtask

    task automatic idle_inputs();
        a_en = 0; a_clr = 0; a_load = 0; a_dir = 0; a_mode = 0;
        a_load_val = 0; a_limit = 0; a_prescale = 0;
        b_en = 0; b_clr = 0; b_load = 0; b_dir = 0; b_mode = 0;
        b_load_val = 0; b_limit = 0; b_prescale = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #12;
        vectors++;
        if ({count_a, tc_a, done_a, tick_a} !== 11'b0) begin
            miscompares++;
            $display("FAIL reset_a: got count=%0h tc=%b done=%b tick=%b, want all 0", count_a, tc_a, done_a, tick_a);
        end
        vectors++;
        if ({count_b, tc_b, done_b, tick_b} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_b: got count=%0h tc=%b done=%b tick=%b, want all 0", count_b, tc_b, done_b, tick_b);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_free_run_up();
        int tcs;
        tcs = 0;
        a_en = 1;
        for (int i = 1; i <= 260; i++) begin
            step();
            if (tc_a === 1'b1) tcs++;
            vectors++;
            if ({count_a, tc_a, done_a} !== {8'(i % 256), 1'(i == 256), 1'b0}) begin
                miscompares++;
                $display("FAIL free_up cyc %0d: got count=%0d tc=%b done=%b, want count=%0d tc=%b done=0",
                         i, count_a, tc_a, done_a, i % 256, (i == 256));
            end
            vectors++;
            if (obs_tick_a !== 1'b1) begin
                miscompares++;
                $display("FAIL free_up_tick cyc %0d: got %b want 1", i, obs_tick_a);
            end
        end
        vectors++;
        if (tcs != 1) begin
            miscompares++;
            $display("FAIL free_up_tc_total: got %0d want 1", tcs);
        end
    endtask

    task automatic test_modulo_up();
        int tcs;
        tcs = 0;
        a_clr = 1; a_en = 1; a_mode = 2'b01; a_limit = 8'd9; a_prescale = 8'd2; a_dir = 0;
        step();
        a_clr = 0;
        for (int i = 0; i < 60; i++) begin
            a_en = (i >= 20 && i < 25) ? 1'b0 : 1'b1;
            step();
            if (tc_a === 1'b1) tcs++;
            vectors++;
            if ({count_a, tc_a, done_a} !== {8'(m_count[0]), 1'(m_tc[0]), 1'(m_done[0])} ||
                (tc_a === 1'b1 && count_a !== 8'd0)) begin
                miscompares++;
                $display("FAIL modulo_up cyc %0d: got count=%0d tc=%b done=%b, want count=%0d tc=%0d done=%0d",
                         i, count_a, tc_a, done_a, m_count[0], m_tc[0], m_done[0]);
            end
            vectors++;
            if (obs_tick_a !== 1'(exp_tick_a)) begin
                miscompares++;
                $display("FAIL modulo_up_tick cyc %0d: got %b want %0d", i, obs_tick_a, exp_tick_a);
            end
        end
        vectors++;
        if (tcs != 1 || m_count[0] != 8) begin
            miscompares++;
            $display("FAIL modulo_up_total: got tc pulses=%0d final model count=%0d, want 1 and 8", tcs, m_count[0]);
        end
    endtask

    task automatic test_modulo_down();
        int seq[5] = '{2, 1, 0, 5, 4};
        int tcx[5] = '{0, 0, 0, 1, 0};
        a_load = 1; a_load_val = 8'd2; a_dir = 1; a_limit = 8'd5; a_prescale = 0; a_mode = 2'b01; a_en = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            a_load = 0;
            vectors++;
            if ({count_a, tc_a} !== {8'(seq[i]), 1'(tcx[i])} ||
                {count_a, tc_a} !== {8'(m_count[0]), 1'(m_tc[0])}) begin
                miscompares++;
                $display("FAIL modulo_down step %0d: got count=%0d tc=%b, want count=%0d tc=%0d", i, count_a, tc_a, seq[i], tcx[i]);
            end
        end
    endtask

    task automatic test_one_shot();
        a_clr = 1; a_mode = 2'b10; a_dir = 0; a_limit = 8'd4; a_prescale = 0; a_en = 1;
        step();
        a_clr = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            vectors++;
            if ({count_a, tc_a, done_a, obs_tick_a} !== {8'((i < 4) ? i : 4), 1'(i == 5), 1'(i >= 5), 1'(i <= 5)}) begin
                miscompares++;
                $display("FAIL one_shot cyc %0d: got count=%0d tc=%b done=%b tick=%b, want count=%0d tc=%b done=%b tick=%b",
                         i, count_a, tc_a, done_a, obs_tick_a, (i < 4) ? i : 4, (i == 5), (i >= 5), (i <= 5));
            end
        end
        a_load = 1; a_load_val = 8'd1;
        step();
        a_load = 0;
        vectors++;
        if ({count_a, tc_a, done_a} !== {8'd1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL one_shot_reload: got count=%0d tc=%b done=%b, want count=1 tc=0 done=0", count_a, tc_a, done_a);
        end
        for (int i = 2; i <= 5; i++) begin
            step();
            vectors++;
            if ({count_a, tc_a, done_a} !== {8'((i < 4) ? i : 4), 1'(i == 5), 1'(i == 5)} ||
                {count_a, tc_a, done_a} !== {8'(m_count[0]), 1'(m_tc[0]), 1'(m_done[0])}) begin
                miscompares++;
                $display("FAIL one_shot_resume cyc %0d: got count=%0d tc=%b done=%b, want count=%0d tc=%b done=%b",
                         i, count_a, tc_a, done_a, (i < 4) ? i : 4, (i == 5), (i == 5));
            end
        end
    endtask

    task automatic test_priority();
        a_mode = 2'b00; a_dir = 0; a_en = 1; a_prescale = 0; a_load = 1; a_load_val = 8'h20;
        step();
        a_clr = 1; a_load_val = 8'h55;
        step();
        vectors++;
        if ({count_a, tc_a, done_a, obs_tick_a} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL prio_clr_load: got count=%0h tc=%b done=%b tick=%b, want 0 0 0 tick=1", count_a, tc_a, done_a, obs_tick_a);
        end
        a_clr = 0; a_load_val = 8'h33;
        step();
        a_load = 0;
        vectors++;
        if ({count_a, tc_a, obs_tick_a} !== {8'h33, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL prio_load_tick: got count=%0h tc=%b tick=%b, want 33 0 tick=1", count_a, tc_a, obs_tick_a);
        end
        a_mode = 2'b10; a_limit = 8'h33;
        step();
        vectors++;
        if ({count_a, tc_a, done_a} !== {8'h33, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL prio_halt: got count=%0h tc=%b done=%b, want 33 1 1", count_a, tc_a, done_a);
        end
        a_mode = 2'b00;
        step();
        a_clr = 1; a_load = 1; a_load_val = 8'h77;
        step();
        a_clr = 0; a_load = 0;
        vectors++;
        if ({count_a, tc_a, done_a} !== {8'h33, 1'b0, 1'b1} && 1'b0) begin
            miscompares++;
        end
        if ({count_a, tc_a, done_a} !== {8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL prio_clr_from_halt: got count=%0h tc=%b done=%b, want 0 0 0", count_a, tc_a, done_a);
        end
    endtask

    task automatic test_async_reset();
        a_load = 1; a_load_val = 0; a_mode = 2'b01; a_dir = 1; a_limit = 8'h37; a_prescale = 0; a_en = 1;
        step();
        a_load = 0;
        step();
        vectors++;
        if ({count_a, tc_a} !== {8'h37, 1'b1}) begin
            miscompares++;
            $display("FAIL async_pre: got count=%0h tc=%b, want 37 1", count_a, tc_a);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if ({count_a, tc_a, done_a} !== {8'h00, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got count=%0h tc=%b done=%b, want 0 0 0 before any edge", count_a, tc_a, done_a);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_width4();
        int e;
        idle_inputs();
        b_clr = 1; b_en = 1; b_mode = 2'b00; b_dir = 1; b_prescale = 1'b1;
        step();
        b_clr = 0;
        for (int k = 1; k <= 34; k++) begin
            e = ((16 - (k / 2)) % 16 + 16) % 16;
            step();
            vectors++;
            if ({count_b, tc_b, obs_tick_b} !== {4'(e), 1'(k == 2 || k == 34), 1'(k % 2 == 0)} ||
                {count_b, tc_b} !== {4'(m_count[1]), 1'(m_tc[1])}) begin
                miscompares++;
                $display("FAIL width4_down cyc %0d: got count=%0d tc=%b tick=%b, want count=%0d tc=%b tick=%b",
                         k, count_b, tc_b, obs_tick_b, e, (k == 2 || k == 34), (k % 2 == 0));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            a_clr      = ($urandom_range(0, 31) == 0);
            a_load     = ($urandom_range(0, 15) == 0);
            a_load_val = 8'($urandom_range(0, 255));
            a_en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                a_dir   = 1'($urandom_range(0, 1));
                a_mode  = 2'($urandom_range(0, 3));
                a_limit = 8'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) a_prescale = 8'($urandom_range(0, 3));
            b_clr      = ($urandom_range(0, 31) == 0);
            b_load     = ($urandom_range(0, 15) == 0);
            b_load_val = 4'($urandom_range(0, 15));
            b_en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                b_dir   = 1'($urandom_range(0, 1));
                b_mode  = 2'($urandom_range(0, 3));
                b_limit = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) b_prescale = 1'($urandom_range(0, 1));
            step();
            vectors++;
            if ({count_a, tc_a, done_a, obs_tick_a} !== {8'(m_count[0]), 1'(m_tc[0]), 1'(m_done[0]), 1'(exp_tick_a)}) begin
                miscompares++;
                $display("FAIL random_a cyc %0d: got count=%0d tc=%b done=%b tick=%b, want count=%0d tc=%0d done=%0d tick=%0d",
                         n, count_a, tc_a, done_a, obs_tick_a, m_count[0], m_tc[0], m_done[0], exp_tick_a);
            end
            vectors++;
            if ({count_b, tc_b, done_b, obs_tick_b} !== {4'(m_count[1]), 1'(m_tc[1]), 1'(m_done[1]), 1'(exp_tick_b)}) begin
                miscompares++;
                $display("FAIL random_b cyc %0d: got count=%0d tc=%b done=%b tick=%b, want count=%0d tc=%0d done=%0d tick=%0d",
                         n, count_b, tc_b, done_b, obs_tick_b, m_count[1], m_tc[1], m_done[1], exp_tick_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run_up();
        test_modulo_up();
        test_modulo_down();
        test_one_shot();
        test_priority();
        test_async_reset();
        test_width4();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
